submatrix_reader: RTL
=====================

# submatrix_reader

Read-side engine for the 240x240 linear frame buffer that the pixel-address counter fills. It fetches a rectangular window (x0, y0, win_w, win_h) from synchronous RAM in row-major order and streams the pixels out on a valid/ready interface, tagged with coordinates and a last flag. It sits between the frame-buffer RAM read port and downstream consumers such as the VGA/submatrix processing path.

## Interface
- IMG_W, 240, image width in pixels
- IMG_H, 240, image height in pixels
- ADDR_W, 16, frame-buffer address width; must hold IMG_W*IMG_H-1 (57599)
- DATA_W, 8, pixel width
- COORD_W, 8, width of x/y/size fields
- clock  in  1  rising-edge clock
- resetN  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- x0, y0  in  COORD_W  window origin; sampled with start
- win_w, win_h  in  COORD_W  window size; sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the final beat is accepted
- mem_rden  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM address, y*IMG_W+x
- mem_q  in  DATA_W  RAM data, valid exactly 1 cycle after mem_rden
- out_valid  out  1  pixel beat valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  DATA_W  pixel
- out_x, out_y  out  COORD_W  absolute image coordinates of the beat
- out_last  out  1  marks the final pixel of the window

## Operation
- FSM: IDLE -> RUN on start; RUN -> DRAIN after the last read is issued; DRAIN -> IDLE when the output buffer is empty and the last beat is accepted (done pulses in that cycle). The sampled window is empty when win_w==0 or win_h==0: IDLE -> DONE -> IDLE, with done pulsing 1 cycle after start and no reads or beats.
- Address generation: row_base = y0*IMG_W loaded at start, then row_base += IMG_W at each row end; the column counter runs x0 .. x0+win_w-1, then wraps to x0. All address arithmetic is modulo IMG_W*IMG_H: an address past 57599 wraps to 0.
- Output buffer: 2-entry FIFO of {data, x, y, last}. A read is issued in a cycle iff in RUN and fifo_count + inflight - pop < 2, where pop = out_valid && out_ready. This sustains 1 beat/cycle with out_ready held high.
- Beats are strictly row-major; out_x/out_y/out_last travel with the data through the FIFO.
- start while busy is ignored: no restart and no parameter reload.
- Output stability: while out_valid && !out_ready, out_data/out_x/out_y/out_last hold.
- Reset: all outputs 0, state IDLE, FIFO empty, inflight cleared. A read returning after reset is discarded. Reset mid-window abandons the window with no done.

## Timing
- Cycle 0: start high in IDLE.
- Cycle 1: busy=1, mem_rden=1, mem_addr=y0*IMG_W+x0.
- Cycle 2: mem_q captured into the FIFO.
- Cycle 3: first out_valid. Start-to-first-beat latency is 3 cycles.
- With out_ready held at 1, beats are continuous: the last beat of a W*H window appears at cycle 2+W*H, and done pulses that same cycle, coincident with acceptance of out_last.
- Cycle after done: busy=0, and a new start is accepted.
- If out_ready falls, at most 2 beats are buffered and no reads are issued until a slot frees. mem_q is never dropped.

## Configuration
- SUBMATRIX_CLIP_EN defined: at start, the effective win_w = min(win_w, IMG_W-x0) and win_h = min(win_h, IMG_H-y0). An origin outside the image (x0>=IMG_W or y0>=IMG_H) gives an empty window (done only). out_x/out_y always stay in range.
- SUBMATRIX_CLIP_EN undefined: the window is used as given. Columns past IMG_W run into the next row's addresses, and addresses past 57599 wrap to 0. out_x/out_y report the unclipped counters modulo 2^COORD_W.

## Test plan
- Window x0=0, y0=0, win 2x2, out_ready=1 -> mem_addr 0,1,240,241 on cycles 1-4; beats (0,0),(1,0),(0,1),(1,1); out_last and done on cycle 6; busy low on cycle 7.
- Window x0=10, y0=5, win 3x1, with out_ready low for cycles 3-6 -> at most 2 reads outstanding; out_data holds; beats resume in order with addresses 1210,1211,1212.
- win_w=0 -> done pulses on cycle 1; mem_rden and out_valid stay 0.
- Window x0=238, y0=239, win 4x1: with SUBMATRIX_CLIP_EN, 2 beats at addresses 57598, 57599; without it, 4 beats at addresses 57598, 57599, 0, 1.
- start asserted again mid-window -> ignored; the original window completes unchanged.
- resetN low for one cycle mid-window -> all outputs 0 the next cycle; no done; a subsequent start runs cleanly.

Source files
------------

// File: rtl/submatrix_reader_if.sv
`default_nettype none
// =============================================================================
// submatrix_reader_if: pixel-beat stream (valid/ready) tagged with x/y/last.
// Revision: 1.0
// =============================================================================
interface submatrix_reader_if #(
    parameter int DATA_W  = 8,
    parameter int COORD_W = 8
);
    logic               valid;
    logic               ready;
    logic [DATA_W-1:0]  data;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               last;

    modport master (output valid, data, x, y, last, input ready);
    modport slave  (input valid, data, x, y, last, output ready);
endinterface
`default_nettype wire

// File: rtl/submatrix_reader.sv
`default_nettype none
// =============================================================================
// submatrix_reader: streams a rectangular window of the frame buffer in
// row-major order; define SUBMATRIX_CLIP_EN to clip the window to the image.
// Revision: 1.0
// =============================================================================
module submatrix_reader #(
    parameter int IMG_W   = 240,
    parameter int IMG_H   = 240,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int COORD_W = 8
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] win_w,
    input  logic [COORD_W-1:0] win_h,
    output logic               busy,
    output logic               done,
    output logic               mem_rden,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_q,
    submatrix_reader_if.master out
);

    localparam int TOTAL = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    // a and b are each below TOTAL, so one conditional subtract is a full modulo
    function automatic logic [ADDR_W-1:0] wrap_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = a + b;
        if (s >= 32'(TOTAL))
            s = s - 32'(TOTAL);
        return ADDR_W'(s);
    endfunction

    // window parameters and address-generation state
    logic [COORD_W-1:0] x0_q, win_w_q, win_h_q;
    logic [COORD_W-1:0] col, row, cur_x, cur_y;
    logic [ADDR_W-1:0]  row_base, addr;

    // one read in flight, with its tags waiting for the RAM data
    logic               inflight;
    logic [COORD_W-1:0] pend_x, pend_y;
    logic               pend_last;

    // 2-entry output FIFO
    logic [DATA_W-1:0]  fifo_data [2];
    logic [COORD_W-1:0] fifo_x    [2];
    logic [COORD_W-1:0] fifo_y    [2];
    logic               fifo_last [2];
    logic               rd_ptr, wr_ptr;
    logic [1:0]         count;

    logic [COORD_W-1:0] eff_w, eff_h;
    logic               win_empty;
    logic [ADDR_W-1:0]  start_base, start_addr, next_base, next_row_addr;
    logic               pop, last_read;
    logic [2:0]         occupancy;

`ifdef SUBMATRIX_CLIP_EN
    always_comb begin
        eff_w = win_w;
        eff_h = win_h;
        if (32'(x0) >= 32'(IMG_W))
            eff_w = '0;
        else if (32'(win_w) > 32'(IMG_W) - 32'(x0))
            eff_w = COORD_W'(32'(IMG_W) - 32'(x0));
        if (32'(y0) >= 32'(IMG_H))
            eff_h = '0;
        else if (32'(win_h) > 32'(IMG_H) - 32'(y0))
            eff_h = COORD_W'(32'(IMG_H) - 32'(y0));
    end
`else
    assign eff_w = win_w;
    assign eff_h = win_h;
`endif

    assign win_empty     = (eff_w == '0) || (eff_h == '0);
    assign start_base    = wrap_add(32'(y0) * 32'(IMG_W), 32'd0);
    assign start_addr    = wrap_add(32'(start_base), 32'(x0));
    assign next_base     = wrap_add(32'(row_base), 32'(IMG_W));
    assign next_row_addr = wrap_add(32'(next_base), 32'(x0_q));

    assign pop       = out.valid && out.ready;
    assign last_read = (col == win_w_q - COORD_W'(1)) && (row == win_h_q - COORD_W'(1));
    // slots already promised (buffered + in flight) after this cycle's pop
    assign occupancy = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign mem_rden  = (state == RUN) && (occupancy < 3'd2);
    assign mem_addr  = addr;
    assign busy      = (state != IDLE);

    assign out.valid = (count != 2'd0);
    assign out.data  = fifo_data[rd_ptr];
    assign out.x     = fifo_x[rd_ptr];
    assign out.y     = fifo_y[rd_ptr];
    assign out.last  = fifo_last[rd_ptr];

    always_ff @(posedge clock) begin
        if (!resetN)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = win_empty ? DONE : RUN;
            end
            RUN: begin
                if (mem_rden && last_read)
                    state_next = DRAIN;
            end
            DRAIN: begin
                // the tagged last beat is the final entry, so its pop empties the FIFO
                if (pop && out.last) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            x0_q      <= '0;
            win_w_q   <= '0;
            win_h_q   <= '0;
            col       <= '0;
            row       <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            row_base  <= '0;
            addr      <= '0;
            inflight  <= 1'b0;
            pend_x    <= '0;
            pend_y    <= '0;
            pend_last <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_x[i]    <= '0;
                fifo_y[i]    <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (state == IDLE && start) begin
                x0_q     <= x0;
                win_w_q  <= eff_w;
                win_h_q  <= eff_h;
                col      <= '0;
                row      <= '0;
                cur_x    <= x0;
                cur_y    <= y0;
                row_base <= start_base;
                addr     <= start_addr;
            end else if (mem_rden) begin
                if (col == win_w_q - COORD_W'(1)) begin
                    col      <= '0;
                    row      <= row + COORD_W'(1);
                    cur_x    <= x0_q;
                    cur_y    <= cur_y + COORD_W'(1);
                    row_base <= next_base;
                    addr     <= next_row_addr;
                end else begin
                    col   <= col + COORD_W'(1);
                    cur_x <= cur_x + COORD_W'(1);
                    addr  <= wrap_add(32'(addr), 32'd1);
                end
            end

            inflight <= mem_rden;
            if (mem_rden) begin
                pend_x    <= cur_x;
                pend_y    <= cur_y;
                pend_last <= last_read;
            end

            if (inflight) begin
                fifo_data[wr_ptr] <= mem_q;
                fifo_x[wr_ptr]    <= pend_x;
                fifo_y[wr_ptr]    <= pend_y;
                fifo_last[wr_ptr] <= pend_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule
`default_nettype wire
